// File: rtl/gsim_job_arbiter_if.sv
// Requester and result handshake bundle for the GSIM job arbiter.
// Slave is the arbiter side; master is the requester/consumer side.
interface gsim_job_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*16-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic                res_valid;
    logic [31:0]         res_data;
    logic [ID_W-1:0]     res_id;
    logic                res_last;
    logic                res_ready;

    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_data, res_id, res_last
    );

    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_data, res_id, res_last
    );
endinterface

// File: rtl/gsim_job_arbiter.sv
// Round-robin job arbiter sharing one GSIM solver between N_REQ requesters.
// Loads a 16-word b frame, captures the 16-word x burst, drains it tagged.
module gsim_job_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ID_W      = 2,
    parameter int FRAME_LEN = 16
) (
    input  logic              clk,
    input  logic              reset,
    gsim_job_arbiter_if.slave bus,
    output logic              gsim_in_en,
    output logic [15:0]       gsim_b_in,
    input  logic              gsim_out_valid,
    input  logic [31:0]       gsim_x_out,
    output logic              busy,
    output logic              err_spurious
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] CAPTURE = 3'd3;
    localparam logic [2:0] DRAIN   = 3'd4;

    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    logic [2:0]      state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] pick;
    logic            found;
    logic [3:0]      load_cnt;
    logic [3:0]      cap_cnt;
    logic [3:0]      rd_idx;
    logic [31:0]     buf_mem [FRAME_LEN];
    logic            ld_hs;
    logic            cap_we;
    logic            drain;
    logic [3:0]      cap_idx;
    logic [15:0]     word;

    function automatic logic [ID_W-1:0] rr_slot(
        input logic [ID_W-1:0] base,
        input int              k
    );
        return ID_W'((int'(base) + k) % N_REQ);
    endfunction

    // first requesting slot after the last one served, wrapping
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && bus.req_valid[rr_slot(rr_ptr, k)]) begin
                found = 1'b1;
                pick  = rr_slot(rr_ptr, k);
            end
        end
    end

    assign word    = bus.req_data[{grant, 4'b0000} +: 16];
    assign ld_hs   = (state == LOAD) && bus.req_valid[grant];
    assign cap_we  = gsim_out_valid &&
                     ((state == WAIT) || (state == CAPTURE));
    assign cap_idx = (state == WAIT) ? 4'd0 : cap_cnt;
    assign drain   = (state == DRAIN);

    assign bus.req_ready = (state == LOAD) ? (N_REQ'(1) << grant) : '0;
    assign bus.res_valid = drain;
    assign bus.res_data  = drain ? buf_mem[rd_idx] : '0;
    assign bus.res_id    = drain ? grant : '0;
    assign bus.res_last  = drain && (rd_idx == LAST_IDX);
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            rr_ptr       <= ID_W'(N_REQ - 1);
            grant        <= '0;
            load_cnt     <= '0;
            cap_cnt      <= '0;
            rd_idx       <= '0;
            gsim_in_en   <= 1'b0;
            gsim_b_in    <= '0;
            err_spurious <= 1'b0;
        end else begin
            gsim_in_en <= ld_hs;
            if (ld_hs)
                gsim_b_in <= word;
            if (gsim_out_valid && !cap_we)
                err_spurious <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant <= pick;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (ld_hs) begin
                        load_cnt <= load_cnt + 4'd1;
                        if (load_cnt == LAST_IDX)
                            state <= WAIT;
                    end
                end
                WAIT: begin
                    if (gsim_out_valid) begin
                        cap_cnt <= 4'd1;
                        state   <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (gsim_out_valid) begin
                        cap_cnt <= cap_cnt + 4'd1;
                        if (cap_cnt == LAST_IDX) begin
                            rd_idx <= '0;
                            state  <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.res_ready) begin
                        rd_idx <= rd_idx + 4'd1;
                        if (rd_idx == LAST_IDX) begin
                            rr_ptr <= grant;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // result buffer needs no reset; it is gated off outside DRAIN
    always_ff @(posedge clk) begin
        if (cap_we)
            buf_mem[cap_idx] <= gsim_x_out;
    end

endmodule

// File: tb/tb_gsim_job_arbiter.sv
// Bench for gsim_job_arbiter: vector table of arbitration rounds,
// directed corner sequences and randomized jobs against a phase model.
module tb_gsim_job_arbiter;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        gsim_in_en;
    logic [15:0] gsim_b_in;
    logic        gsim_out_valid;
    logic [31:0] gsim_x_out;
    logic        busy;
    logic        err_spurious;

    gsim_job_arbiter_if #(.N_REQ(N), .ID_W(2)) bus();

    gsim_job_arbiter #(.N_REQ(N), .ID_W(2), .FRAME_LEN(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .gsim_in_en     (gsim_in_en),
        .gsim_b_in      (gsim_b_in),
        .gsim_out_valid (gsim_out_valid),
        .gsim_x_out     (gsim_x_out),
        .busy           (busy),
        .err_spurious   (err_spurious)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // requesters and stub solver
    logic        act   [N];
    int          pos   [N];
    logic [15:0] fr    [N][16];
    logic        gap_m [N];
    logic        skip  [N];
    int          drop_pct, rr_drop, stall_cnt;
    logic        rr_stall;
    logic [15:0] sol_q [$];
    int          sol_wait, sol_emit, sol_d;
    logic        sol_hole, hole_done, inj_spur;
    int          in_en_cnt, res_cnt, last_pos;

    // reference model: job phase 0 idle, 1 load, 2 solve, 3 drain
    int          m_ph, m_g, m_last, m_nacc, m_ncap, m_nrd;
    logic        m_err, m_in_en;
    logic [15:0] m_b;
    logic [15:0] m_fr [16];
    int          order_q [$];

    typedef struct {
        logic [3:0] mask;
        int         n;
        int         ord [4];
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic reset_all();
        for (int i = 0; i < N; i++) begin
            act[i] = 1'b0; pos[i] = 0; gap_m[i] = 1'b0; skip[i] = 1'b0;
        end
        drop_pct = 0; rr_drop = 0; rr_stall = 1'b0; stall_cnt = 0;
        sol_q.delete(); sol_wait = 0; sol_emit = 0; sol_d = 5;
        sol_hole = 1'b0; hole_done = 1'b0; inj_spur = 1'b0;
        m_ph = 0; m_g = 0; m_last = N - 1; m_nacc = 0; m_ncap = 0;
        m_nrd = 0; m_err = 1'b0; m_in_en = 1'b0; m_b = '0;
        bus.req_valid = '0; bus.req_data = '0; bus.res_ready = 1'b0;
        gsim_out_valid = 1'b0; gsim_x_out = '0;
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_in_en", 32'(gsim_in_en), 32'd0);
        chk("rst_b_in", 32'(gsim_b_in), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_data", bus.res_data, 32'd0);
        chk("rst_res_id", 32'(bus.res_id), 32'd0);
        chk("rst_res_last", 32'(bus.res_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_spurious), 32'd0);
        reset_all();
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic start_req(input int i, input logic gap,
                             input logic ramp);
        act[i] = 1'b1; pos[i] = 0; gap_m[i] = gap; skip[i] = 1'b0;
        for (int w = 0; w < 16; w++)
            fr[i][w] = ramp ? 16'(w + 1) : 16'($urandom);
    endtask

    task automatic check_outputs();
        chk("busy", 32'(busy), 32'(m_ph != 0));
        chk("err_spurious", 32'(err_spurious), 32'(m_err));
        chk("req_ready", 32'(bus.req_ready),
            (m_ph == 1) ? (32'd1 << m_g) : 32'd0);
        chk("in_en", 32'(gsim_in_en), 32'(m_in_en));
        if (m_in_en)
            chk("b_in", 32'(gsim_b_in), 32'(m_b));
        chk("res_valid", 32'(bus.res_valid), 32'(m_ph == 3));
        if (m_ph == 3) begin
            chk("res_data", bus.res_data, {m_fr[m_nrd], 16'h0000});
            chk("res_id", 32'(bus.res_id), 32'(m_g));
            chk("res_last", 32'(bus.res_last), 32'(m_nrd == 15));
        end
    endtask

    task automatic model_step(input logic [3:0] v, input logic ov,
                              input logic rr);
        int idx;
        m_in_en = 1'b0;
        if (ov && m_ph != 2)
            m_err = 1'b1;
        case (m_ph)
            0: if (v != 0) begin
                for (int k = N; k >= 1; k--) begin
                    idx = (m_last + k) % N;
                    if (v[idx]) m_g = idx;
                end
                order_q.push_back(m_g);
                m_nacc = 0;
                m_ph = 1;
            end
            1: if (v[m_g]) begin
                m_in_en = 1'b1;
                m_b = fr[m_g][pos[m_g]];
                m_fr[m_nacc] = m_b;
                m_nacc++;
                if (m_nacc == 16) begin m_ph = 2; m_ncap = 0; end
            end
            2: if (ov) begin
                m_ncap++;
                if (m_ncap == 16) begin m_ph = 3; m_nrd = 0; end
            end
            default: if (rr) begin
                m_nrd++;
                if (m_nrd == 16) begin m_last = m_g; m_ph = 0; end
            end
        endcase
    endtask

    task automatic cycle();
        logic [3:0]  v, rdy;
        logic        ov, rr, rv, rl, stall;
        logic [31:0] x;
        @(negedge clk);
        check_outputs();
        rdy = bus.req_ready; rv = bus.res_valid; rl = bus.res_last;
        if (gsim_in_en) begin
            sol_q.push_back(gsim_b_in);
            in_en_cnt++;
            if (sol_q.size() == 16) sol_wait = sol_d;
        end
        ov = 1'b0; x = '0;
        if (sol_emit > 0) begin
            if (sol_hole && sol_emit == 8 && !hole_done) begin
                hole_done = 1'b1;
            end else begin
                ov = 1'b1;
                x = {sol_q[16 - sol_emit], 16'h0000};
                sol_emit--;
                if (sol_emit == 0) begin sol_q.delete(); hole_done = 1'b0; end
            end
        end else if (sol_wait > 0) begin
            sol_wait--;
            if (sol_wait == 0) sol_emit = 16;
        end
        if (inj_spur && m_ph == 1 && m_nacc == 5 && !ov) begin
            ov = 1'b1; x = $urandom; inj_spur = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            v[i] = act[i] && !skip[i] &&
                   (int'($urandom_range(99)) >= drop_pct);
            bus.req_data[16*i +: 16] = act[i] ? fr[i][pos[i] & 15] : 16'h0;
        end
        stall = rr_stall && m_ph == 3 && m_nrd == 7 && stall_cnt < 5;
        if (stall) stall_cnt++;
        rr = !stall && (int'($urandom_range(99)) >= rr_drop);
        bus.req_valid = v; bus.res_ready = rr;
        gsim_out_valid = ov; gsim_x_out = x;
        if (rv && rr) begin
            res_cnt++;
            if (rl) last_pos = res_cnt;
        end
        model_step(v, ov, rr);
        for (int i = 0; i < N; i++) begin
            if (v[i] && rdy[i]) begin
                pos[i]++;
                if (pos[i] == 16) act[i] = 1'b0;
            end
            skip[i] = v[i] && rdy[i] && gap_m[i];
        end
    endtask

    function automatic logic all_idle();
        logic any = 1'b0;
        for (int i = 0; i < N; i++) any |= act[i];
        return !any && m_ph == 0 && sol_emit == 0 && sol_wait == 0;
    endfunction

    task automatic run_jobs(input int budget);
        int n = 0;
        while (n < budget && !all_idle()) begin
            cycle();
            n++;
        end
        chk("job_timeout", 32'(n >= budget), 32'd0);
        cycle();
    endtask

    task automatic clr_counts();
        in_en_cnt = 0; res_cnt = 0; last_pos = 0; order_q.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{mask: 4'b1011, n: 3, ord: '{0, 1, 3, 0}};
        tbl[1] = '{mask: 4'b0101, n: 2, ord: '{0, 2, 0, 0}};
        tbl[2] = '{mask: 4'b1111, n: 4, ord: '{3, 0, 1, 2}};
        tbl[3] = '{mask: 4'b1001, n: 2, ord: '{3, 0, 0, 0}};
        tbl[4] = '{mask: 4'b0011, n: 2, ord: '{1, 0, 0, 0}};
        tbl[5] = '{mask: 4'b1100, n: 2, ord: '{2, 3, 0, 0}};

        reset = 1'b1;
        reset_all();
        do_reset();

        for (int r = 0; r < 6; r++) begin
            clr_counts();
            for (int i = 0; i < N; i++)
                if (tbl[r].mask[i]) start_req(i, 1'b0, 1'b0);
            run_jobs(3000);
            chk("tbl_jobs", 32'(order_q.size()), 32'(tbl[r].n));
            for (int k = 0; k < tbl[r].n && k < order_q.size(); k++)
                chk("tbl_grant", 32'(order_q[k]), 32'(tbl[r].ord[k]));
        end

        // requester 0 ramp 1..16, solver latency 100
        clr_counts();
        sol_d = 100;
        start_req(0, 1'b0, 1'b1);
        run_jobs(3000);
        chk("basic_in_en_cnt", 32'(in_en_cnt), 32'd16);
        chk("basic_res_cnt", 32'(res_cnt), 32'd16);
        chk("basic_last_pos", 32'(last_pos), 32'd16);
        chk("basic_jobs", 32'(order_q.size()), 32'd1);
        chk("basic_busy", 32'(busy), 32'd0);
        sol_d = 5;

        // requester 2 leaves a gap after every word
        clr_counts();
        start_req(2, 1'b1, 1'b0);
        run_jobs(3000);
        chk("gap_in_en_cnt", 32'(in_en_cnt), 32'd16);
        chk("gap_res_cnt", 32'(res_cnt), 32'd16);

        // consumer stalls 5 cycles at word 7
        clr_counts();
        rr_stall = 1'b1; stall_cnt = 0;
        start_req(1, 1'b0, 1'b0);
        run_jobs(3000);
        chk("stall_cycles", 32'(stall_cnt), 32'd5);
        chk("stall_res_cnt", 32'(res_cnt), 32'd16);
        chk("stall_last_pos", 32'(last_pos), 32'd16);
        rr_stall = 1'b0;

        // spurious solver strobe while loading
        clr_counts();
        inj_spur = 1'b1;
        start_req(3, 1'b0, 1'b0);
        run_jobs(3000);
        for (int i = 0; i < 4; i++) cycle();
        chk("spur_err_sticky", 32'(err_spurious), 32'd1);
        chk("spur_res_cnt", 32'(res_cnt), 32'd16);

        // reset with load_cnt at 9, then a clean job from requester 1
        clr_counts();
        start_req(0, 1'b0, 1'b0);
        begin
            int n = 0;
            while (n < 200 && !(m_ph == 1 && m_nacc == 9)) begin
                cycle();
                n++;
            end
            chk("rst_wait_timeout", 32'(n >= 200), 32'd0);
        end
        do_reset();
        clr_counts();
        start_req(1, 1'b0, 1'b0);
        run_jobs(3000);
        chk("post_rst_res_cnt", 32'(res_cnt), 32'd16);
        chk("post_rst_jobs", 32'(order_q.size()), 32'd1);

        // randomized jobs with request drops, stalls and capture holes
        drop_pct = 20; rr_drop = 30;
        for (int it = 0; it < 25; it++) begin
            logic [3:0] mask;
            mask = 4'($urandom_range(15, 1));
            sol_d = int'($urandom_range(20, 1));
            sol_hole = 1'($urandom_range(1));
            for (int i = 0; i < N; i++)
                if (mask[i]) start_req(i, 1'($urandom_range(1)), 1'b0);
            run_jobs(6000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gsim_job_arbiter.md
Name: gsim_job_arbiter

Overview:
- Shares one GSIM Gauss-Seidel solver core between N_REQ requesters.
- Arbitrates round-robin between requesters that present a 16-word b-vector frame.
- Streams the granted frame into the solver's in_en/b_in interface, captures the 16-word x result burst (the solver cannot be stalled), then drains it to the requester over a valid/ready port tagged with the requester id.
- One job is in flight at a time.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of requester id; equals ceil(log2(N_REQ))
- FRAME_LEN, 16, words per frame in both directions; fixed by the solver

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  bit i: requester i has a frame word available
- req_data  in  N_REQ*16  signed b word; requester i uses bits [16i+15:16i]
- req_ready  out  N_REQ  bit i: word from requester i accepted this cycle if valid
- gsim_in_en  out  1  solver input strobe (registered)
- gsim_b_in  out  16  solver b word (registered)
- gsim_out_valid  in  1  solver result strobe; 16 consecutive cycles per job
- gsim_x_out  in  32  solver result word (Q16.16)
- res_valid  out  1  result word valid
- res_data  out  32  result word
- res_id  out  ID_W  requester that owns the result
- res_last  out  1  high with result word 15
- res_ready  in  1  downstream accepts result word
- busy  out  1  high in any state except IDLE
- err_spurious  out  1  sticky: gsim_out_valid seen outside WAIT/CAPTURE

Behaviour:
- Reset (reset=0, asynchronous) forces the following; the system must reset the solver in the same cycle:
  - state=IDLE
  - rr_ptr=N_REQ-1
  - all counters 0
  - req_ready=0, gsim_in_en=0, gsim_b_in=0
  - res_valid=0, res_data=0, res_id=0, res_last=0
  - busy=0, err_spurious=0
- States: IDLE, LOAD, WAIT, CAPTURE, DRAIN.
- IDLE: if any req_valid bit is set, grant the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
  - The grant is registered; state goes to LOAD on the next edge.
  - No word is accepted in the arbitration cycle.
- LOAD: req_ready[grant]=1; all other req_ready bits are 0.
  - Each req_valid[grant]&req_ready[grant] cycle: gsim_in_en=1 and gsim_b_in=word on the next edge; load_cnt increments.
  - Cycles without a handshake drive gsim_in_en=0. Gaps are legal.
  - After the handshake at load_cnt=15, go to WAIT; req_ready drops on the same edge.
- WAIT: req_ready=0. On gsim_out_valid, write gsim_x_out to buf[0], set cap_cnt=1, go to CAPTURE.
- CAPTURE: every gsim_out_valid cycle writes buf[cap_cnt] and increments cap_cnt.
  - On the write of index 15, go to DRAIN with rd_idx=0.
  - A gsim_out_valid low cycle inside CAPTURE is tolerated; capture resumes on the next strobe.
- DRAIN:
  - Outputs: res_valid=1, res_data=buf[rd_idx], res_id=grant, res_last=(rd_idx==15).
  - These outputs stay stable while res_ready=0.
  - On handshake rd_idx increments. On the handshake with res_last: rr_ptr=grant, state=IDLE, res_valid=0 on the next edge.
- Result latency: the first res_valid occurs 1 cycle after the edge capturing word 15. Buffer depth is 16x32.
- gsim_out_valid in IDLE, LOAD or DRAIN: the word is ignored and err_spurious is set; it stays set until reset.
- req_valid of non-granted requesters is ignored until the next IDLE. Requesters must hold req_valid while waiting. Requests are never dropped.
- A requester deasserting req_valid before its grant is legal. If no bit remains set in IDLE, stay in IDLE.
- Fairness: a requester that re-requests immediately after its job completes is served after every other pending requester.
- Wrap-around: the round-robin search wraps from N_REQ-1 to 0. load_cnt, cap_cnt and rd_idx are 4-bit and wrap to 0 at job end.
- Reset mid-job discards the buffer contents and the partially loaded frame.

Test Plan:
- Stub solver echoes {b,16'h0000} 100 cycles after the 16th in_en, over 16 consecutive cycles. Requester 0 sends b=1..16 with no gaps, res_ready=1 -> gsim_in_en high 16 cycles with b_in 1..16; res_data 32'h0001_0000..32'h0010_0000 with res_id=0; res_last on word 16; busy back to 0.
- Requesters 0, 1, 3 valid simultaneously after reset -> grants in order 0, 1, 3. After job 3, requester 0 re-requests and requester 2 requests -> grant 0 (rr_ptr=3), then 2.
- Requester 2 inserts a 1-cycle gap after every word -> exactly 16 in_en pulses; b_in never duplicated; WAIT entered after the 16th handshake only.
- res_ready low for 5 cycles at rd_idx=7 -> res_data holds word 7 and res_valid stays high; no word lost; IDLE reached only after the res_last handshake.
- Stub pulses gsim_out_valid once while in LOAD -> err_spurious=1 and stays set; the job still completes with correct data.
- Assert reset for 1 cycle at load_cnt=9 -> all outputs take reset values asynchronously; the next job from requester 1 completes normally.
